mdu_ctrl: RTL

- EX-stage multiply/divide control unit. Decodes MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and owns the architectural HI/LO registers.
- Computes multiplies internally with a fixed latency.
- Sequences the iterative 32-bit divider through its start/abandon/ready handshake.
- Stalls the pipeline until each result is written to HI/LO.

---
 rtl/mdu_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/mdu_ctrl.sv
// EX-stage multiply/divide control: decodes MDU ops, owns HI/LO, runs a fixed-latency
// multiplier and sequences an external iterative divider through start/abandon/ready.
module mdu_ctrl #(
  parameter int unsigned MUL_LAT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [2:0]  ex_op,
  input  logic [31:0] ex_opa,
  input  logic [31:0] ex_opb,
  input  logic        flush,
  output logic        stall_out,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        div_start,
  output logic        div_abandon,
  output logic        div_signed,
  output logic [31:0] div_opr1,
  output logic [31:0] div_opr2,
  input  logic        div_ready,
  input  logic [63:0] div_res
);

  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;
  localparam logic [2:0] OpMthi  = 3'd5;
  localparam logic [2:0] OpMtlo  = 3'd6;
  localparam logic [3:0] CntInit = 4'(MUL_LAT - 1);

  typedef enum logic [1:0] {StIdle, StMul, StDivRun, StDivRel} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic        mul_sgn_q, mul_sgn_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] opr1_q, opr1_d, opr2_q, opr2_d;
  logic        sgn_q, sgn_d, start_q, start_d;
  logic        rel_q, rel_d;

  logic is_mul, is_div, is_md, is_mt;
  logic [63:0] ext_a, ext_b, prod;

  assign is_mul = ex_valid & ((ex_op == OpMult) | (ex_op == OpMultu));
  assign is_div = ex_valid & ((ex_op == OpDiv) | (ex_op == OpDivu));
  assign is_md  = is_mul | is_div;
  assign is_mt  = ex_valid & ((ex_op == OpMthi) | (ex_op == OpMtlo));

  // Sign- or zero-extend to 64 bits; the low 64 bits of the product are exact either way.
  assign ext_a = {{32{mul_sgn_q & mul_a_q[31]}}, mul_a_q};
  assign ext_b = {{32{mul_sgn_q & mul_b_q[31]}}, mul_b_q};
  assign prod  = ext_a * ext_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      mul_sgn_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      opr1_q    <= '0;
      opr2_q    <= '0;
      sgn_q     <= 1'b0;
      start_q   <= 1'b0;
      rel_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mul_a_q   <= mul_a_d;
      mul_b_q   <= mul_b_d;
      mul_sgn_q <= mul_sgn_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      opr1_q    <= opr1_d;
      opr2_q    <= opr2_d;
      sgn_q     <= sgn_d;
      start_q   <= start_d;
      rel_q     <= rel_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    mul_sgn_d = mul_sgn_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    opr1_d    = opr1_q;
    opr2_d    = opr2_q;
    sgn_d     = sgn_q;
    start_d   = start_q;
    rel_d     = rel_q;
    unique case (state_q)
      StIdle: begin
        if (!flush) begin
          if (is_mt) begin
            if (ex_op == OpMthi) hi_d = ex_opa;
            else                 lo_d = ex_opa;
          end else if (is_mul) begin
            mul_a_d   = ex_opa;
            mul_b_d   = ex_opb;
            mul_sgn_d = (ex_op == OpMult);
            cnt_d     = CntInit;
            state_d   = StMul;
          end else if (is_div) begin
            opr1_d  = ex_opa;
            opr2_d  = ex_opb;
            sgn_d   = (ex_op == OpDiv);
            start_d = 1'b1;
            state_d = StDivRun;
          end
        end
      end
      StMul: begin
        if (flush) begin
          state_d = StIdle;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          {hi_d, lo_d} = prod;
          state_d      = StIdle;
        end
      end
      StDivRun: begin
        // Abandon wins over a coincident ready: the result is discarded.
        if (flush || div_ready) begin
          if (!flush) begin
            hi_d = div_res[63:32];
            lo_d = div_res[31:0];
          end
          start_d = 1'b0;
          rel_d   = 1'b0;
          state_d = StDivRel;
        end
      end
      StDivRel: begin
        // Linger at least two cycles so the divider sees start low and returns to free.
        rel_d = 1'b1;
        if (rel_q && !div_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    stall_out   = 1'b0;
    div_abandon = 1'b0;
    unique case (state_q)
      StIdle:   stall_out = is_md & ~flush;
      StMul:    stall_out = ~flush & (cnt_q != 4'd0);
      StDivRun: begin
        div_abandon = flush;
        stall_out   = ~flush & ~div_ready;
      end
      StDivRel: stall_out = is_md | is_mt;
      default:  stall_out = 1'b0;
    endcase
  end

  assign hi_out     = hi_q;
  assign lo_out     = lo_q;
  assign div_start  = start_q;
  assign div_signed = sgn_q;
  assign div_opr1   = opr1_q;
  assign div_opr2   = opr2_q;

endmodule
